// File: rtl/shortest_path_pkg.sv
// Shared definitions for the grid shortest-path solver and its traceback stage.
// Contents:
//   D_WIDTH_DEF / A_WIDTH_DEF : default memory data and address widths
//   DIR_START/RIGHT/DOWN      : direction codes stored in the P memory
//   state_t                   : traceback FSM state encoding
package shortest_path_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 16;

    // The solver stage writes these codes into P, so they must stay in step.
    localparam logic [7:0] DIR_START = 8'h08;
    localparam logic [7:0] DIR_RIGHT = 8'h09;
    localparam logic [7:0] DIR_DOWN  = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COST_RD,
        ST_COST_CAP,
        ST_P_RD,
        ST_P_CAP,
        ST_R_WR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/sp_cell_addr.sv
// Combinational (row, column) -> linear cell index row*SIZE_ROW+col.
// Ports:
//   i_Row  : row index
//   i_Col  : column index
//   o_Addr : linear cell index, A_WIDTH unsigned
module sp_cell_addr
    import shortest_path_pkg::*;
#(
    parameter int SIZE_ROW = 4,
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int RW       = 2,
    parameter int CW       = 2
) (
    input  logic [RW-1:0]      i_Row,
    input  logic [CW-1:0]      i_Col,
    output logic [A_WIDTH-1:0] o_Addr
);

    assign o_Addr = A_WIDTH'(i_Row) * A_WIDTH'(SIZE_ROW) + A_WIDTH'(i_Col);

endmodule

// File: rtl/shortest_path_traceback.sv
// Traceback stage of the grid shortest-path solver. Reads the total cost from
// L[LAST], then walks the P direction memory from the bottom-right cell back to
// the start cell, writing each visited cell index into R so that R[0] holds the
// start cell. Malformed walks end early with an Err pulse alongside Done.
// Ports:
//   Clk, Rst                 : clock, synchronous active-high reset
//   i_Go                     : start request, only honoured in IDLE
//   i_L_In / i_P_In          : L / P read data, one cycle after the read strobe
//   o_L_Addr/o_L_En/o_L_Rw   : L memory read port
//   o_P_Addr/o_P_En/o_P_Rw   : P memory read port
//   o_R_Out/o_R_Addr/o_R_En/o_R_Rw : route memory write port
//   o_Cost, o_Steps          : result of the last run, held until the next Go
//   o_Done, o_Err            : one-cycle end-of-run pulses
module shortest_path_traceback
    import shortest_path_pkg::*;
#(
    parameter int SIZE_ROW = 4,
    parameter int NUM_ROWS = 4,
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int A_WIDTH  = A_WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               i_Go,
    input  logic [D_WIDTH-1:0] i_L_In,
    input  logic [D_WIDTH-1:0] i_P_In,
    output logic [A_WIDTH-1:0] o_L_Addr,
    output logic               o_L_En,
    output logic               o_L_Rw,
    output logic [A_WIDTH-1:0] o_P_Addr,
    output logic               o_P_En,
    output logic               o_P_Rw,
    output logic [D_WIDTH-1:0] o_R_Out,
    output logic [A_WIDTH-1:0] o_R_Addr,
    output logic               o_R_En,
    output logic               o_R_Rw,
    output logic [D_WIDTH-1:0] o_Cost,
    output logic [D_WIDTH-1:0] o_Steps,
    output logic               o_Done,
    output logic               o_Err
);

    localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CW   = (SIZE_ROW > 1) ? $clog2(SIZE_ROW) : 1;
    localparam int LAST = NUM_ROWS * SIZE_ROW - 1;
    localparam int PLEN = NUM_ROWS + SIZE_ROW - 1;
    localparam int KW   = $clog2(PLEN + 1);

    state_t             r_State;
    state_t             w_NextState;
    logic [RW-1:0]      r_Row;
    logic [CW-1:0]      r_Col;
    logic [KW-1:0]      r_K;
    logic [D_WIDTH-1:0] r_Dir;
    logic [D_WIDTH-1:0] r_Cost;
    logic [D_WIDTH-1:0] r_Steps;
    logic               r_ErrFlag;
    logic               w_Bad;
    logic [A_WIDTH-1:0] w_CellAddr;

    sp_cell_addr #(
        .SIZE_ROW (SIZE_ROW),
        .A_WIDTH  (A_WIDTH),
        .RW       (RW),
        .CW       (CW)
    ) u_cell_addr (
        .i_Row  (r_Row),
        .i_Col  (r_Col),
        .o_Addr (w_CellAddr)
    );

    // Next-state and Moore strobe decode. A step is only taken when the stored
    // direction points at a cell still inside the grid; every other case ends
    // the run with the error flag, which also bounds the walk to PLEN cells.
    always_comb begin
        w_NextState = r_State;
        w_Bad       = 1'b0;
        o_L_Addr    = '0;
        o_L_En      = 1'b0;
        o_L_Rw      = 1'b0;
        o_P_Addr    = '0;
        o_P_En      = 1'b0;
        o_P_Rw      = 1'b0;
        o_R_Out     = '0;
        o_R_Addr    = '0;
        o_R_En      = 1'b0;
        o_R_Rw      = 1'b0;
        o_Done      = 1'b0;
        o_Err       = 1'b0;
        case (r_State)
            ST_IDLE: begin
                if (i_Go) w_NextState = ST_COST_RD;
            end
            ST_COST_RD: begin
                o_L_En      = 1'b1;
                o_L_Addr    = A_WIDTH'(LAST);
                w_NextState = ST_COST_CAP;
            end
            ST_COST_CAP: w_NextState = ST_P_RD;
            ST_P_RD: begin
                o_P_En      = 1'b1;
                o_P_Addr    = w_CellAddr;
                w_NextState = ST_P_CAP;
            end
            ST_P_CAP: w_NextState = ST_R_WR;
            ST_R_WR: begin
                o_R_En   = 1'b1;
                o_R_Rw   = 1'b1;
                o_R_Addr = A_WIDTH'(PLEN - 1) - A_WIDTH'(r_K);
                o_R_Out  = D_WIDTH'(w_CellAddr);
                if (r_Dir == D_WIDTH'(DIR_START) && r_Row == '0 && r_Col == '0)
                    w_NextState = ST_FIN;
                else if (r_Dir == D_WIDTH'(DIR_RIGHT) && r_Col != '0)
                    w_NextState = ST_P_RD;
                else if (r_Dir == D_WIDTH'(DIR_DOWN) && r_Row != '0)
                    w_NextState = ST_P_RD;
                else begin
                    w_NextState = ST_FIN;
                    w_Bad       = 1'b1;
                end
            end
            ST_FIN: begin
                o_Done      = 1'b1;
                o_Err       = r_ErrFlag;
                w_NextState = ST_IDLE;
            end
            default: w_NextState = ST_IDLE;
        endcase
    end

    // State register and walk datapath. The position only moves when the
    // decoder has accepted the step, so a failing cell is written but never left.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_State   <= ST_IDLE;
            r_Row     <= '0;
            r_Col     <= '0;
            r_K       <= '0;
            r_Dir     <= '0;
            r_Cost    <= '0;
            r_Steps   <= '0;
            r_ErrFlag <= 1'b0;
        end else begin
            r_State <= w_NextState;
            case (r_State)
                ST_IDLE: begin
                    if (i_Go) begin
                        r_Row     <= RW'(NUM_ROWS - 1);
                        r_Col     <= CW'(SIZE_ROW - 1);
                        r_K       <= '0;
                        r_Cost    <= '0;
                        r_Steps   <= '0;
                        r_ErrFlag <= 1'b0;
                    end
                end
                ST_COST_CAP: r_Cost <= i_L_In;
                ST_P_CAP:    r_Dir  <= i_P_In;
                ST_R_WR: begin
                    r_K       <= r_K + KW'(1);
                    r_Steps   <= D_WIDTH'(r_K) + D_WIDTH'(1);
                    r_ErrFlag <= w_Bad;
                    if (w_NextState == ST_P_RD) begin
                        if (r_Dir == D_WIDTH'(DIR_RIGHT)) r_Col <= r_Col - CW'(1);
                        else                              r_Row <= r_Row - RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Cost  = r_Cost;
    assign o_Steps = r_Steps;

endmodule

// File: tb/tb_shortest_path_traceback.sv
// Directed self-checking bench for shortest_path_traceback on a 4x4 grid with
// behavioural L, P (1-cycle sync read) and R (sync write) memories.
module tb_shortest_path_traceback;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Go  = 1'b0;
    logic [7:0]  L_In, P_In;
    logic [15:0] L_Addr, P_Addr, R_Addr;
    logic        L_En, L_Rw, P_En, P_Rw, R_En, R_Rw;
    logic [7:0]  R_Out, Cost, Steps;
    logic        Done, Err;

    logic [7:0]  Lmem [16];
    logic [7:0]  Pmem [16];
    logic [7:0]  Rmem [16];
    int          doneCount = 0;
    logic        badRead   = 1'b0;
    int          testsRun  = 0;
    int          testsFailed = 0;

    always #5 Clk = ~Clk;

    shortest_path_traceback dut (
        .Clk(Clk), .Rst(Rst), .i_Go(Go), .i_L_In(L_In), .i_P_In(P_In),
        .o_L_Addr(L_Addr), .o_L_En(L_En), .o_L_Rw(L_Rw),
        .o_P_Addr(P_Addr), .o_P_En(P_En), .o_P_Rw(P_Rw),
        .o_R_Out(R_Out), .o_R_Addr(R_Addr), .o_R_En(R_En), .o_R_Rw(R_Rw),
        .o_Cost(Cost), .o_Steps(Steps), .o_Done(Done), .o_Err(Err)
    );

    // Behavioural memories plus an out-of-range read detector.
    always @(posedge Clk) begin
        L_In <= (L_En && !L_Rw && L_Addr < 16) ? Lmem[L_Addr[3:0]] : 8'h00;
        P_In <= (P_En && !P_Rw && P_Addr < 16) ? Pmem[P_Addr[3:0]] : 8'h00;
        if (R_En && R_Rw && R_Addr < 16) Rmem[R_Addr[3:0]] <= R_Out;
        if ((L_En && L_Addr > 15) || (P_En && P_Addr > 15) || (R_En && R_Addr > 15))
            badRead <= 1'b1;
        if (Done) doneCount <= doneCount + 1;
    end

    task automatic clearMem();
        for (int i = 0; i < 16; i++) begin
            Lmem[i] = 8'h00;
            Pmem[i] = 8'h00;
            Rmem[i] = 8'hFF;
        end
    endtask

    // Pulse Go for one cycle and count cycles from the accepting edge until Done.
    task automatic doRun(output int cyc, output logic errAtDone);
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0; cyc = 1;
        while (!Done && cyc < 100) begin
            @(negedge Clk); cyc++;
        end
        errAtDone = Err;
        testsRun++;
        if (!Done) begin
            testsFailed++;
            $display("[TB] FAIL run_timeout: no Done within %0d cycles", cyc);
        end
    endtask

    task automatic checkRoute(input string name, input logic [7:0] exp [7]);
        for (int i = 0; i < 7; i++) begin
            testsRun++;
            if (Rmem[i] !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL %s R[%0d]: got %0d expected %0d", name, i, Rmem[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        testsRun++;
        if ({L_Addr, L_En, L_Rw, P_Addr, P_En, P_Rw, R_Out, R_Addr, R_En, R_Rw,
             Cost, Steps, Done, Err} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: L_En=%b P_En=%b R_En=%b Cost=%0d Steps=%0d Done=%b expected all 0",
                     L_En, P_En, R_En, Cost, Steps, Done);
        end
        Rst = 1'b0;
    endtask

    task automatic test_lshape();
        int cyc; logic e; int d0;
        logic [7:0] exp [7] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd13, 8'd14, 8'd15};
        clearMem();
        Pmem[15] = 8'h09; Pmem[14] = 8'h09; Pmem[13] = 8'h09;
        Pmem[12] = 8'h0A; Pmem[8] = 8'h0A; Pmem[4] = 8'h0A; Pmem[0] = 8'h08;
        Lmem[15] = 8'd20;
        d0 = doneCount;
        doRun(cyc, e);
        testsRun++;
        if (cyc != 24) begin testsFailed++; $display("[TB] FAIL lshape_latency: got %0d expected 24", cyc); end
        testsRun++;
        if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL lshape_err: got %b expected 0", e); end
        repeat (4) @(negedge Clk);
        checkRoute("lshape", exp);
        testsRun++;
        if (Steps !== 8'd7) begin testsFailed++; $display("[TB] FAIL lshape_steps: got %0d expected 7", Steps); end
        testsRun++;
        if (Cost !== 8'd20) begin testsFailed++; $display("[TB] FAIL lshape_cost: got %0d expected 20", Cost); end
        testsRun++;
        if (doneCount - d0 != 1) begin testsFailed++; $display("[TB] FAIL lshape_done_count: got %0d expected 1", doneCount - d0); end
    endtask

    task automatic test_staircase();
        int cyc; logic e;
        logic [7:0] exp [7] = '{8'd0, 8'd4, 8'd5, 8'd9, 8'd10, 8'd14, 8'd15};
        clearMem();
        Pmem[15] = 8'h09; Pmem[14] = 8'h0A; Pmem[10] = 8'h09; Pmem[9] = 8'h0A;
        Pmem[5] = 8'h09; Pmem[4] = 8'h0A; Pmem[0] = 8'h08;
        Lmem[15] = 8'd37;
        doRun(cyc, e);
        @(negedge Clk);
        checkRoute("stair", exp);
        testsRun++;
        if (Cost !== 8'd37 || Steps !== 8'd7 || e !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stair_result: Cost=%0d Steps=%0d Err=%b expected 37 7 0", Cost, Steps, e);
        end
    endtask

    task automatic test_bad_code();
        int cyc; logic e;
        clearMem();
        Pmem[15] = 8'h55;
        doRun(cyc, e);
        @(negedge Clk);
        testsRun++;
        if (cyc != 6 || e !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL badcode_done_err: cycles=%0d Err=%b expected 6 1", cyc, e);
        end
        testsRun++;
        if (Rmem[6] !== 8'd15 || Steps !== 8'd1 || Rmem[5] !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL badcode_write: R6=%0d R5=%0d Steps=%0d expected 15 255 1", Rmem[6], Rmem[5], Steps);
        end
    endtask

    task automatic test_right_edge();
        int cyc; logic e;
        clearMem();
        Pmem[15] = 8'h09; Pmem[14] = 8'h09; Pmem[13] = 8'h09; Pmem[12] = 8'h09;
        badRead = 1'b0;
        doRun(cyc, e);
        @(negedge Clk);
        testsRun++;
        if (e !== 1'b1 || Steps !== 8'd4 || cyc != 15) begin
            testsFailed++;
            $display("[TB] FAIL rightedge_err: Err=%b Steps=%0d cycles=%0d expected 1 4 15", e, Steps, cyc);
        end
        testsRun++;
        if (Rmem[3] !== 8'd12 || badRead !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rightedge_bounds: R3=%0d badRead=%b expected 12 0", Rmem[3], badRead);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc; logic e; int d0;
        logic [7:0] exp [7] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd13, 8'd14, 8'd15};
        clearMem();
        Pmem[15] = 8'h09; Pmem[14] = 8'h09; Pmem[13] = 8'h09;
        Pmem[12] = 8'h0A; Pmem[8] = 8'h0A; Pmem[4] = 8'h0A; Pmem[0] = 8'h08;
        d0 = doneCount;
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
        repeat (8) @(negedge Clk);
        testsRun++;
        if (P_En !== 1'b1 || P_Addr !== 16'd13) begin
            testsFailed++;
            $display("[TB] FAIL midrun_third_prd: P_En=%b P_Addr=%0d expected 1 13", P_En, P_Addr);
        end
        Rst = 1'b1;
        @(negedge Clk);
        testsRun++;
        if ({L_En, P_En, R_En, P_Addr, R_Addr, R_Out, Cost, Steps, Done, Err} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_reset_outputs: P_En=%b P_Addr=%0d R_En=%b Done=%b expected all 0",
                     P_En, P_Addr, R_En, Done);
        end
        Rst = 1'b0;
        repeat (30) @(negedge Clk);
        testsRun++;
        if (doneCount != d0) begin testsFailed++; $display("[TB] FAIL midrun_no_done: got %0d Done pulses expected 0", doneCount - d0); end
        clearMem();
        Pmem[15] = 8'h09; Pmem[14] = 8'h09; Pmem[13] = 8'h09;
        Pmem[12] = 8'h0A; Pmem[8] = 8'h0A; Pmem[4] = 8'h0A; Pmem[0] = 8'h08;
        doRun(cyc, e);
        @(negedge Clk);
        checkRoute("after_reset", exp);
        testsRun++;
        if (Steps !== 8'd7 || cyc != 24) begin
            testsFailed++;
            $display("[TB] FAIL after_reset_run: Steps=%0d cycles=%0d expected 7 24", Steps, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        clearMem();
        Pmem[15] = 8'h55;
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); cyc = 1;
        while (!Done && cyc < 100) begin @(negedge Clk); cyc++; end
        testsRun++;
        if (cyc != 6) begin testsFailed++; $display("[TB] FAIL b2b_first: got %0d expected 6", cyc); end
        @(negedge Clk);
        testsRun++;
        if (L_En !== 1'b0 || Done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_idle_gap: L_En=%b Done=%b expected 0 0", L_En, Done);
        end
        @(negedge Clk);
        testsRun++;
        if (L_En !== 1'b1 || L_Addr !== 16'd15) begin
            testsFailed++;
            $display("[TB] FAIL b2b_retrigger: L_En=%b L_Addr=%0d expected 1 15", L_En, L_Addr);
        end
        cyc = 1;
        while (!Done && cyc < 100) begin
            @(negedge Clk); cyc++;
            if (cyc == 3) Go = 1'b0;
            if (cyc == 4) Go = 1'b1;
        end
        Go = 1'b0;
        testsRun++;
        if (cyc != 6 || Err !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: cycles=%0d Err=%b expected 6 1", cyc, Err);
        end
        repeat (3) @(negedge Clk);
        testsRun++;
        if (L_En !== 1'b0 || P_En !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_stop: L_En=%b P_En=%b expected 0 0", L_En, P_En);
        end
    endtask

    initial begin
        clearMem();
        test_reset();
        test_lshape();
        test_staircase();
        test_bad_code();
        test_right_edge();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
